pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline. Combines load-use hazards (ID vs EX),
//  taken-branch flushes (EX), multi-cycle MUL/DIV ops in EX (start/done handshake) and data-memory
//  wait states (MEM) into one set of PC/IF-ID/ID-EX/EX-MEM enables and bubbles. Replaces per-stage
//  ad-hoc hazard logic; keeps stall/flush counters and an MDU-timeout error flag.
// PARAMETERS
//  CNT_W        32   width of the stall/flush event counters (saturating)
//  MDU_TIMEOUT  64   max cycles in MDU_WAIT before err_mdu_timeout sets; 0 disables the check
// PORTS
//  clk              in   1      pipeline clock
//  rst_n            in   1      async active-low reset
//  memread_e        in   1      instruction in EX is a load
//  rd_e             in   5      destination register of the instruction in EX
//  rs1_d, rs2_d     in   5      source registers of the instruction in ID
//  rs1_used_d       in   1      ID instruction reads rs1
//  rs2_used_d       in   1      ID instruction reads rs2
//  pcsrc_e          in   1      branch/jump taken, resolved in EX
//  mdu_op_e         in   1      EX holds a multi-cycle MUL/DIV op
//  mdu_done         in   1      MDU result valid this cycle
//  dmem_ready       in   1      data memory completes the MEM-stage access this cycle
//  pc_write         out  1      PC register enable
//  if_id_write      out  1      IF/ID register enable
//  if_id_flush      out  1      IF/ID loads a NOP
//  id_ex_write      out  1      ID/EX register enable
//  id_ex_bubble     out  1      ID/EX control bits cleared (bubble)
//  ex_mem_write     out  1      EX/MEM register enable
//  ex_mem_bubble    out  1      EX/MEM control bits cleared
//  mdu_start        out  1      one-cycle start pulse to the MDU
//  stall_cnt        out  CNT_W  cycles with pc_write=0
//  flush_cnt        out  CNT_W  cycles with if_id_flush=1
//  err_mdu_timeout  out  1      sticky; MDU exceeded MDU_TIMEOUT cycles
// BEHAVIOUR
//  Reset (async): state=RUN, counters=0, timeout counter=0, err=0. While rst_n=0: all *_write=1,
//   flush/bubble=0, mdu_start=0.
//  Enables/flushes are combinational from state+inputs (act on the same edge); counters registered.
//  FSM states: RUN, MDU_WAIT.
//   RUN -> MDU_WAIT when mdu_op_e=1 and freeze=0; mdu_start=1 that cycle only. EX is held.
//   MDU_WAIT: mdu_start=0; hold until mdu_done=1; in the done cycle EX releases -> RUN.
//   mdu_done in RUN is ignored.
//  Condition priority (highest first), evaluated each cycle:
//   1 freeze = !dmem_ready: all *_write=0, no flush/bubble; FSM holds; pcsrc_e deferred.
//   2 mdu_hold = (RUN & mdu_op_e) | (MDU_WAIT & !mdu_done): pc/if_id/id_ex_write=0,
//     ex_mem_bubble=1, ex_mem_write=1. pcsrc_e ignored (EX not yet complete).
//   3 pcsrc_e: if_id_flush=1, id_ex_bubble=1, pc_write=1; load-use is suppressed.
//   4 load_use = memread_e & rd_e!=0 & ((rs1_used_d & rs1_d==rd_e) | (rs2_used_d & rs2_d==rd_e)):
//     pc_write=0, if_id_write=0, id_ex_bubble=1.
//   else all *_write=1, no flush/bubble.
//  rd_e==x0 never causes a load-use stall.
//  stall_cnt +1 each cycle pc_write=0 (rst_n high); flush_cnt +1 each cycle if_id_flush=1; both
//   saturate at all-ones.
//  Timeout counter clears on entry to MDU_WAIT and counts each MDU_WAIT cycle (frozen cycles
//   included); reaching MDU_TIMEOUT sets err_mdu_timeout. Cleared only by reset. FSM is unaffected.
//  Reset mid-MDU: returns to RUN immediately; mdu_start is not re-issued until the next RUN
//   cycle with mdu_op_e=1.
// STRUCTURE
//  pipe_ctrl_pkg: state enum (ST_RUN, ST_MDU_WAIT), cause enum (C_NONE, C_FREEZE, C_MDU,
//   C_FLUSH, C_LOADUSE), REG_X0 constant.
//  One sub-module: load_use_detect (combinational compare -> load_use). FSM, priority mux and
//   counters stay in pipe_stall_ctrl.
// TESTING
//  1 memread_e=1, rd_e=5, rs1_d=5, rs1_used_d=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1
//    for 1 cycle; stall_cnt=1. Repeat with rd_e=0 -> no stall.
//  2 Same load-use plus pcsrc_e=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_cnt
//    unchanged, flush_cnt=1.
//  3 mdu_op_e=1; mdu_done at cycle 4 -> mdu_start only on cycle 0; cycles 0-3
//    pc_write=0, ex_mem_bubble=1; cycle 4 all writes=1; state back to RUN; stall_cnt=4.
//  4 dmem_ready=0 for 3 cycles during MDU_WAIT with pcsrc_e=1 -> all *_write=0, no flush;
//    FSM stays in MDU_WAIT; flush acts only after mdu_done.
//  5 MDU_TIMEOUT=8, mdu_done never -> err_mdu_timeout=1 after cycle 8, stays 1; async
//    rst_n pulse -> err=0, state=RUN, counters=0.
//  6 Force stall_cnt near all-ones (CNT_W=4), 20 stall cycles -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush scheduler
package pipe_ctrl_pkg;
  typedef enum logic {ST_RUN, ST_MDU_WAIT} state_t;
  typedef enum logic [2:0] {C_NONE, C_FREEZE, C_MDU, C_FLUSH, C_LOADUSE} cause_t;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage source that depends on a load currently in EX
//   in:  memread_e, rd_e, rs1_d, rs2_d, rs1_used_d, rs2_used_d
//   out: load_use
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       memread_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       rs1_used_d,
  input  logic       rs2_used_d,
  output logic       load_use
);
  assign load_use = memread_e && rd_e != REG_X0 &&
                    ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush scheduler combining memory wait, MDU, branch and load-use hazards
//   in:  clk, rst_n, memread_e, rd_e, rs1_d, rs2_d, rs1_used_d, rs2_used_d, pcsrc_e, mdu_op_e, mdu_done, dmem_ready
//   out: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, ex_mem_bubble,
//        mdu_start, stall_cnt, flush_cnt, err_mdu_timeout
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memread_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic             pcsrc_e,
  input  logic             mdu_op_e,
  input  logic             mdu_done,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             ex_mem_bubble,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_mdu_timeout
);
  state_t      state, state_nx;
  cause_t      cause;
  logic        load_use, mdu_hold;
  logic [31:0] tmo_cnt;
  load_use_detect u_lud (
    .memread_e (memread_e),
    .rd_e      (rd_e),
    .rs1_d     (rs1_d),
    .rs2_d     (rs2_d),
    .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d),
    .load_use  (load_use)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_RUN;
    else state <= state_nx;
  // a memory wait freezes the FSM along with every pipeline register
  always_comb
    state_nx = !dmem_ready ? state :
               state == ST_RUN ? (mdu_op_e ? ST_MDU_WAIT : ST_RUN) :
               (mdu_done ? ST_RUN : ST_MDU_WAIT);
  always_comb begin
    mdu_hold      = (state == ST_RUN && mdu_op_e) || (state == ST_MDU_WAIT && !mdu_done);
    cause         = !dmem_ready ? C_FREEZE : mdu_hold ? C_MDU : pcsrc_e ? C_FLUSH :
                    load_use ? C_LOADUSE : C_NONE;
    // in reset the pipeline free-runs so it can drain to NOPs
    pc_write      = !rst_n || cause == C_NONE || cause == C_FLUSH;
    if_id_write   = pc_write;
    if_id_flush   = rst_n && cause == C_FLUSH;
    id_ex_write   = !rst_n || !(cause == C_FREEZE || cause == C_MDU);
    id_ex_bubble  = rst_n && (cause == C_FLUSH || cause == C_LOADUSE);
    ex_mem_write  = !rst_n || cause != C_FREEZE;
    ex_mem_bubble = rst_n && cause == C_MDU;
    mdu_start     = rst_n && state == ST_RUN && mdu_op_e && dmem_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt       <= '0;
      flush_cnt       <= '0;
      tmo_cnt         <= '0;
      err_mdu_timeout <= 1'b0;
    end else begin
      if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (state == ST_RUN && state_nx == ST_MDU_WAIT) tmo_cnt <= '0;
      else if (state == ST_MDU_WAIT && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 32'd1;
      if (MDU_TIMEOUT != 0 && state == ST_MDU_WAIT && tmo_cnt + 32'd1 == 32'(MDU_TIMEOUT))
        err_mdu_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed vector and sequence checks for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
  localparam logic [7:0] O_NONE = 8'b11010100;
  localparam logic [7:0] O_FRZ  = 8'b00000000;
  localparam logic [7:0] O_MDU0 = 8'b00000111;
  localparam logic [7:0] O_MDUW = 8'b00000110;
  localparam logic [7:0] O_FL   = 8'b11111100;
  localparam logic [7:0] O_LU   = 8'b00011100;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       mr, u1, u2, pc, op, dn, rdy;
  logic [4:0] rd, r1, r2;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, ex_mem_bubble, mdu_start, err;
  logic [3:0] stall_cnt, flush_cnt;
  logic       n_pw, n_iw, n_if, n_ew, n_eb, n_mw, n_mb, n_ms, n_err;
  logic [3:0] n_sc, n_fc;
  logic [7:0] outs;
  int         passed = 0, total = 0;
  typedef struct {
    logic       mr;
    logic [4:0] rd, r1, r2;
    logic       u1, u2, pc, op, dn, rdy;
    logic [7:0] exp;
    string      name;
  } vec_t;
  vec_t tv[13];
  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, ex_mem_bubble, mdu_start};
  always #5 clk = ~clk;
  pipe_stall_ctrl #(.CNT_W(4), .MDU_TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .memread_e(mr), .rd_e(rd), .rs1_d(r1), .rs2_d(r2),
    .rs1_used_d(u1), .rs2_used_d(u2), .pcsrc_e(pc), .mdu_op_e(op), .mdu_done(dn), .dmem_ready(rdy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write), .ex_mem_bubble(ex_mem_bubble),
    .mdu_start(mdu_start), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_mdu_timeout(err)
  );
  pipe_stall_ctrl #(.CNT_W(4), .MDU_TIMEOUT(0)) u_nt (
    .clk(clk), .rst_n(rst_n), .memread_e(mr), .rd_e(rd), .rs1_d(r1), .rs2_d(r2),
    .rs1_used_d(u1), .rs2_used_d(u2), .pcsrc_e(pc), .mdu_op_e(op), .mdu_done(dn), .dmem_ready(rdy),
    .pc_write(n_pw), .if_id_write(n_iw), .if_id_flush(n_if), .id_ex_write(n_ew),
    .id_ex_bubble(n_eb), .ex_mem_write(n_mw), .ex_mem_bubble(n_mb),
    .mdu_start(n_ms), .stall_cnt(n_sc), .flush_cnt(n_fc), .err_mdu_timeout(n_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic idle();
    mr = 0; rd = 0; r1 = 0; r2 = 0; u1 = 0; u2 = 0; pc = 0; op = 0; dn = 0; rdy = 1;
  endtask
  task automatic drive(input vec_t v);
    mr = v.mr; rd = v.rd; r1 = v.r1; r2 = v.r2; u1 = v.u1; u2 = v.u2;
    pc = v.pc; op = v.op; dn = v.dn; rdy = v.rdy;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 0;
    #2 rst_n = 1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, "idle"};
    tv[1]  = '{1, 5, 5, 0, 1, 0, 0, 0, 0, 1, O_LU,   "lu_rs1"};
    tv[2]  = '{1, 9, 3, 9, 0, 1, 0, 0, 0, 1, O_LU,   "lu_rs2"};
    tv[3]  = '{1, 5, 5, 0, 0, 0, 0, 0, 0, 1, O_NONE, "lu_unused"};
    tv[4]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1, O_NONE, "lu_x0"};
    tv[5]  = '{0, 5, 5, 5, 1, 1, 0, 0, 0, 1, O_NONE, "no_load"};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, O_FL,   "branch"};
    tv[7]  = '{1, 5, 5, 0, 1, 0, 1, 0, 0, 1, O_FL,   "branch_over_lu"};
    tv[8]  = '{1, 5, 5, 0, 1, 0, 1, 0, 0, 0, O_FRZ,  "freeze_all"};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, O_MDU0, "mdu_over_branch"};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,  "mdu_frozen"};
    tv[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE, "done_in_run"};
    tv[12] = '{1, 5, 5, 0, 1, 0, 0, 1, 0, 1, O_MDU0, "mdu_over_lu"};
    idle();
    mr = 1; rd = 5; r1 = 5; u1 = 1; op = 1;
    #1 chk("rst_outs", outs, O_NONE);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_err", err, 0);
    idle();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1 chk(tv[i].name, outs, tv[i].exp);
      #1 idle();
    end
    @(negedge clk);
    do_reset();
    mr = 1; rd = 5; r1 = 5; u1 = 1;
    #1 chk("t1_lu", outs, O_LU);
    tick();
    chk("t1_stall", stall_cnt, 1);
    rd = 0; r1 = 0;
    #1 chk("t1_x0", outs, O_NONE);
    tick();
    chk("t1_stall_x0", stall_cnt, 1);
    @(negedge clk);
    do_reset();
    mr = 1; rd = 5; r1 = 5; u1 = 1; pc = 1;
    #1 chk("t2_flush", outs, O_FL);
    tick();
    chk("t2_stall", stall_cnt, 0);
    chk("t2_flushcnt", flush_cnt, 1);
    @(negedge clk);
    do_reset();
    op = 1;
    #1 chk("t3_start", outs, O_MDU0);
    tick();
    for (int c = 1; c < 4; c++) begin
      chk("t3_wait", outs, O_MDUW);
      tick();
    end
    dn = 1;
    #1 chk("t3_done", outs, O_NONE);
    tick();
    op = 0; dn = 0;
    #1 chk("t3_run", outs, O_NONE);
    chk("t3_stall", stall_cnt, 4);
    op = 1;
    #1 chk("t3_restart", outs, O_MDU0);
    #1 op = 0;
    @(negedge clk);
    do_reset();
    op = 1;
    #1 chk("t4_start", outs, O_MDU0);
    tick();
    rdy = 0; pc = 1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_freeze", outs, O_FRZ);
      tick();
    end
    rdy = 1;
    #1 chk("t4_hold", outs, O_MDUW);
    tick();
    dn = 1;
    #1 chk("t4_flush", outs, O_FL);
    tick();
    chk("t4_flushcnt", flush_cnt, 1);
    chk("t4_stall", stall_cnt, 5);
    @(negedge clk);
    do_reset();
    op = 1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) chk("t5_pre_err", err, 0);
    end
    chk("t5_err", err, 1);
    tick(); tick(); tick();
    chk("t5_sticky", err, 1);
    chk("t5_fsm_wait", outs, O_MDUW);
    chk("t5_disabled", n_err, 0);
    #2 rst_n = 0;
    #1 chk("t5_rst_err", err, 0);
    chk("t5_rst_stall", stall_cnt, 0);
    chk("t5_rst_outs", outs, O_NONE);
    #1 rst_n = 1;
    #1 chk("t5_run", outs, O_MDU0);
    #1 op = 0;
    @(negedge clk);
    do_reset();
    mr = 1; rd = 7; r2 = 7; u2 = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("t6_stall14", stall_cnt, 14);
    end
    chk("t6_sat", stall_cnt, 15);
    chk("t6_outs", outs, O_LU);
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
